// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter, round-robin with a MAX_HOLD bound on tenure.
// Define MEM_ARBITER_FIXED_PRIORITY_EN to give port 0 fixed priority over port 1.
module mem_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_func_in,
    input  logic [2:0]  p0_func_out,
    input  logic [31:0] p0_address,
    input  logic [31:0] p0_data_in,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_data_out,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_func_in,
    input  logic [2:0]  p1_func_out,
    input  logic [31:0] p1_address,
    input  logic [31:0] p1_data_in,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_data_out,
    output logic        mem_we,
    output logic [1:0]  mem_func_in,
    output logic [2:0]  mem_func_out,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, nxt;
    logic [7:0] hold;
    logic       last;
    logic       at_max;

    assign at_max = hold == 8'(MAX_HOLD - 1);

    // last == 1 means port 1 was served most recently, so port 0 wins the next tie
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (p0_req && p1_req) ? ((FIXED || last) ? OWN0 : OWN1) :
                           p0_req ? OWN0 : p1_req ? OWN1 : IDLE;
            OWN0:    nxt = !p0_req ? (p1_req ? OWN1 : IDLE) :
                           (p1_req && at_max && !FIXED) ? OWN1 : OWN0;
            OWN1:    nxt = !p1_req ? (p0_req ? OWN0 : IDLE) :
                           (p0_req && (at_max || FIXED)) ? OWN0 : OWN1;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
            last  <= 1'b1;
        end else begin
            state <= nxt;
            if (nxt != state)
                hold <= '0;
            else if (state != IDLE && !at_max)
                hold <= hold + 8'd1;
            if (nxt != state && nxt != IDLE)
                last <= (nxt == OWN1);
        end
    end

    assign p0_gnt = (state == OWN0);
    assign p1_gnt = (state == OWN1);

    assign mem_we       = (p0_gnt & p0_req & p0_we) | (p1_gnt & p1_req & p1_we);
    assign mem_address  = p0_gnt ? p0_address  : p1_gnt ? p1_address  : '0;
    assign mem_data_in  = p0_gnt ? p0_data_in  : p1_gnt ? p1_data_in  : '0;
    assign mem_func_in  = p0_gnt ? p0_func_in  : p1_gnt ? p1_func_in  : '0;
    assign mem_func_out = p0_gnt ? p0_func_out : p1_gnt ? p1_func_out : '0;

    assign p0_rvalid   = p0_gnt & p0_req & ~p0_we;
    assign p1_rvalid   = p1_gnt & p1_req & ~p1_we;
    assign p0_data_out = p0_gnt ? mem_data_out : '0;
    assign p1_data_out = p1_gnt ? mem_data_out : '0;
endmodule
